// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module : alu_ctrl_pkg
// Brief  : Shared ALU control codes, arbiter FSM encoding and latency limits.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int ALU_LAT_MAX = 7;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_rr_pick.sv
// ============================================================================
// Module : alu_rr_pick
// Brief  : Two-way winner selection; round-robin under ALU_ARB_RR_EN, else fixed.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_pick (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic grant0_o,
  output logic grant1_o
);

`ifdef ALU_ARB_RR_EN
  // last_i is the requester granted most recently; the other one wins a tie.
  assign grant0_o = valid0_i & (~valid1_i | last_i);
  assign grant1_o = valid1_i & (~valid0_i | ~last_i);
`else
  logic unused_last;
  assign unused_last = last_i;
  assign grant0_o    = valid0_i;
  assign grant1_o    = valid1_i & ~valid0_i;
`endif

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Brief  : Shares one ALU between two requesters; ALU_ARB_RR_EN selects round-robin.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_dataA,
  output logic [WIDTH-1:0] alu_dataB,
  input  logic [WIDTH-1:0] alu_dataC
);

  localparam logic [CNT_W-1:0] c_lat = CNT_W'(ALU_LAT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             last_w;
  logic             gnt0_w, gnt1_w;
  logic             accept_w;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  // Pointer starts at req1 so the first tie goes to req0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (accept_w) begin
      last_q <= gnt1_w;
    end
  end

  assign last_w = last_q;
`else
  assign last_w = 1'b1;
`endif

  alu_rr_pick u_pick (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_w),
    .grant0_o (gnt0_w),
    .grant1_o (gnt1_w)
  );

  assign accept_w   = (state_q == ST_IDLE) & (gnt0_w | gnt1_w);
  assign req0_ready = (state_q == ST_IDLE) & gnt0_w;
  assign req1_ready = (state_q == ST_IDLE) & gnt1_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          state_d = ST_EXEC;
          cnt_d   = c_lat;
          id_d    = gnt1_w;
          ctrl_d  = gnt1_w ? req1_op : req0_op;
          a_d     = gnt1_w ? req1_a  : req0_a;
          b_d     = gnt1_w ? req1_b  : req0_b;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          data_d  = alu_dataC;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_id      = id_q;
  assign rsp_data    = data_q;
  assign alu_control = ctrl_q;
  assign alu_dataA   = a_q;
  assign alu_dataB   = b_q;

endmodule

`default_nettype wire
